// File: rtl/buffer_mux_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : buffer_mux_sequencer_if
// Purpose  : Request/grant/select bundle between the round-robin burst
//            sequencer, its 16 sources and the downstream buffer/mux stage.
// Revision : 1.0 - initial release
// ============================================================================
interface buffer_mux_sequencer_if;
  logic        enable;
  logic [15:0] req;
  logic        stall;
  logic [15:0] mux_sel;
  logic [15:0] ack;
  logic        out_valid;
  logic [3:0]  out_ch;
  logic        out_last;

  // Sources / controller side
  modport master (
    output enable, req, stall,
    input  mux_sel, ack, out_valid, out_ch, out_last
  );

  // Sequencer side
  modport slave (
    input  enable, req, stall,
    output mux_sel, ack, out_valid, out_ch, out_last
  );
endinterface
`default_nettype wire

// File: rtl/buffer_mux_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : buffer_mux_sequencer
// Purpose  : Round-robin burst sequencer. Grants one of 16 channels for
//            BURST_LEN beats, drives the one-hot mux select, per-beat acks
//            and beat-aligned valid/channel/last flags for the mux stage.
// Revision : 1.0 - initial release
// ============================================================================
module buffer_mux_sequencer #(
  parameter int unsigned BURST_LEN = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  buffer_mux_sequencer_if.slave         bus
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [7:0] LAST_BEAT = 8'(BURST_LEN - 1);

  state_t      state_q, state_d;
  logic [3:0]  ptr_q, ptr_d;
  logic [7:0]  beat_cnt_q, beat_cnt_d;
  logic [3:0]  grant_idx_q, grant_idx_d;
  logic [15:0] mux_sel_q, mux_sel_d;
  logic        out_valid_q, out_valid_d;
  logic [3:0]  out_ch_q, out_ch_d;
  logic        out_last_q, out_last_d;

  logic [3:0]  arb_start;
  logic [3:0]  arb_idx;
  logic [3:0]  scan_idx;
  logic        arb_found;
  logic        beat_go;
  logic        last_beat;

  // Round-robin pick: first requester at or above the start point, wrapping.
  // In GRANT the only arbitration point is the last beat, where the start
  // point is the channel after the current grant (the ptr value being written).
  always_comb begin
    arb_start = (state_q == GRANT) ? (grant_idx_q + 4'd1) : ptr_q;
    arb_idx   = arb_start;
    arb_found = 1'b0;
    scan_idx  = arb_start;
    for (int i = 0; i < 16; i++) begin
      scan_idx = arb_start + 4'(i);
      if (!arb_found && bus.req[scan_idx]) begin
        arb_idx   = scan_idx;
        arb_found = 1'b1;
      end
    end
  end

  assign beat_go   = (state_q == GRANT) && !bus.stall;
  assign last_beat = beat_go && (beat_cnt_q == LAST_BEAT);

  // Next-state, select and beat-aligned output flag computation.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    beat_cnt_d  = beat_cnt_q;
    grant_idx_d = grant_idx_q;
    mux_sel_d   = mux_sel_q;
    out_valid_d = beat_go;
    out_ch_d    = grant_idx_q;
    out_last_d  = last_beat;

    case (state_q)
      IDLE: begin
        mux_sel_d = 16'h0000;
        if (bus.enable && arb_found) begin
          grant_idx_d = arb_idx;
          mux_sel_d   = 16'h0001 << arb_idx;
          beat_cnt_d  = 8'd0;
          state_d     = GRANT;
        end
      end
      GRANT: begin
        if (last_beat) begin
          ptr_d      = grant_idx_q + 4'd1;
          beat_cnt_d = 8'd0;
          if (bus.enable && arb_found) begin
            grant_idx_d = arb_idx;
            mux_sel_d   = 16'h0001 << arb_idx;
          end else begin
            mux_sel_d = 16'h0000;
            state_d   = IDLE;
          end
        end else if (beat_go) begin
          beat_cnt_d = beat_cnt_q + 8'd1;
        end
      end
      default: begin
        state_d   = IDLE;
        mux_sel_d = 16'h0000;
      end
    endcase
  end

  // State and output registers; reset abandons any burst in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= 4'd0;
      beat_cnt_q  <= 8'd0;
      grant_idx_q <= 4'd0;
      mux_sel_q   <= 16'h0000;
      out_valid_q <= 1'b0;
      out_ch_q    <= 4'd0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      beat_cnt_q  <= beat_cnt_d;
      grant_idx_q <= grant_idx_d;
      mux_sel_q   <= mux_sel_d;
      out_valid_q <= out_valid_d;
      out_ch_q    <= out_ch_d;
      out_last_q  <= out_last_d;
    end
  end

  assign bus.mux_sel   = mux_sel_q;
  assign bus.ack       = mux_sel_q & {16{beat_go}};
  assign bus.out_valid = out_valid_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.out_last  = out_last_q;

endmodule
`default_nettype wire
